// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch-side initiator for a combinational instruction memory. Owns the
// program counter, presents the word address every cycle, and captures each
// returned word together with its byte PC into a small prefetch FIFO that is
// drained by decode through a valid/ready handshake. A redirect flushes the
// FIFO and restarts fetch at a new PC.
//
// Optional feature macro: FETCH_HALT_EN
//   When defined, a pushed word equal to 32'hFFFF_FFFF stops further fetch
//   and raises `halted` until the next redirect or reset. When undefined,
//   `halted` is tied to 0 and that word is fetched like any other.
//
// Parameters:
//   RESET_PC    byte address of the first fetch after reset (bits [1:0] ignored)
//   FIFO_DEPTH  prefetch entries; power of two, at least 2
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous active-high reset
//   imem_addr       word address to instruction memory ({2'b00, pc[31:2]})
//   imem_data       word returned by instruction memory in the same cycle
//   redirect_valid  flush the FIFO and load redirect_pc
//   redirect_pc     new fetch byte address (bits [1:0] forced to 0)
//   out_valid       FIFO head valid
//   out_ready       decode accepts the head this cycle
//   out_instr       instruction at the FIFO head (0 when not valid)
//   out_pc          byte PC of out_instr (0 when not valid)
//   halted          fetch stopped on a halt word (FETCH_HALT_EN only)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]       PC_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0]       RESET_PC_ALIGNED = RESET_PC & PC_MASK;

    // Control state
    logic [31:0]      pc_q,     pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Prefetch storage: data only, never reset; validity comes from count_q
    logic [31:0] fifo_instr_q [FIFO_DEPTH];
    logic [31:0] fifo_pc_q    [FIFO_DEPTH];

    logic push;
    logic pop;
    logic fetch_stop;

    assign imem_addr = {2'b00, pc_q[31:2]};
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;

    always_comb begin
        pop  = out_valid && out_ready;
        // A full FIFO never pushes, even when it is popped in the same cycle.
        push = (count_q != DEPTH_C) && !redirect_valid && !fetch_stop;

        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (redirect_valid) begin
            // Any same-cycle pop is consumed by decode; the queue is then flushed.
            pc_d     = redirect_pc & PC_MASK;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;  // wraps modulo 2^32
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC_ALIGNED;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_data;
            fifo_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

`ifdef FETCH_HALT_EN
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    logic halted_q, halted_d;

    // The halt word itself is enqueued; halting takes effect from the next cycle.
    always_comb begin
        halted_d = halted_q;
        if (redirect_valid) begin
            halted_d = 1'b0;
        end else if (push && (imem_data == HALT_WORD)) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign fetch_stop = halted_q;
`else
    assign fetch_stop = 1'b0;
`endif

    assign halted = fetch_stop;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit with a small combinational memory model.
// Inputs change 1 ns after the rising edge; outputs are checked at the same
// point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[5:0]];

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 | 32'(i);
        mem[0] = 32'hA000_00AA;
        mem[1] = 32'h1000_0011;
        mem[2] = 32'h2000_0022;

        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_valid",  {31'h0, out_valid}, 32'h0);
        chk("rst_pc",     out_pc,    32'h0);
        chk("rst_instr",  out_instr, 32'h0);
        chk("rst_addr",   imem_addr, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);

        // Steady fetch
        reset = 1'b0;
        chk("st_addr0",  imem_addr, 32'h0);
        chk("st_valid0", {31'h0, out_valid}, 32'h0);
        step();
        chk("st_addr1",  imem_addr, 32'h1);
        chk("st_valid1", {31'h0, out_valid}, 32'h1);
        chk("st_pc1",    out_pc,    32'h0);
        chk("st_ins1",   out_instr, 32'hA000_00AA);
        step();
        chk("st_addr2",  imem_addr, 32'h2);
        chk("st_pc2",    out_pc,    32'h4);
        chk("st_ins2",   out_instr, 32'h1000_0011);
        step();
        chk("st_addr3",  imem_addr, 32'h3);
        chk("st_pc3",    out_pc,    32'h8);
        chk("st_ins3",   out_instr, 32'h2000_0022);

        // Backpressure: fill to depth 4, then drain in order
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) step();
        chk("bp_addr",  imem_addr, 32'h4);
        chk("bp_valid", {31'h0, out_valid}, 32'h1);
        chk("bp_pc",    out_pc,    32'h0);
        chk("bp_ins",   out_instr, 32'hA000_00AA);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("bp_drain_pc", out_pc, 32'(4 * i));
        end
        chk("bp_ins16", out_instr, 32'hC000_0004);

        // Redirect with 3 entries queued
        out_ready = 1'b0;
        do_reset();
        step(); step(); step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0043;
        out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("rd_valid0", {31'h0, out_valid}, 32'h0);
        chk("rd_pc0",    out_pc,    32'h0);
        chk("rd_addr0",  imem_addr, 32'h10);
        step();
        chk("rd_valid1", {31'h0, out_valid}, 32'h1);
        chk("rd_pc1",    out_pc,    32'h40);
        chk("rd_ins1",   out_instr, 32'hC000_0010);
        chk("rd_addr1",  imem_addr, 32'h11);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wr_addr0", imem_addr, 32'h3FFF_FFFF);
        step();
        chk("wr_pc0",   out_pc,    32'hFFFF_FFFC);
        chk("wr_ins0",  out_instr, 32'hC000_003F);
        chk("wr_addr1", imem_addr, 32'h0);
        step();
        chk("wr_pc1",   out_pc,    32'h0);
        chk("wr_ins1",  out_instr, 32'hA000_00AA);

        // Reset mid-fetch overrides a pending redirect
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        step(); step();
        chk("rm_valid_pre", {31'h0, out_valid}, 32'h1);
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0080;
        step();
        reset = 1'b0;
        redirect_valid = 1'b0;
        chk("rm_valid", {31'h0, out_valid}, 32'h0);
        chk("rm_addr",  imem_addr, 32'h0);

        // Halt word handling
        mem[2] = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        do_reset();
        step();
        chk("ht_pc0", out_pc, 32'h0);
        step();
        chk("ht_pc1", out_pc, 32'h4);
        step();
        chk("ht_pc2",  out_pc,    32'h8);
        chk("ht_ins2", out_instr, 32'hFFFF_FFFF);
        chk("ht_addr2", imem_addr, 32'h3);
`ifdef FETCH_HALT_EN
        chk("ht_halted", {31'h0, halted}, 32'h1);
        step();
        chk("ht_valid3", {31'h0, out_valid}, 32'h0);
        chk("ht_addr3",  imem_addr, 32'h3);
        chk("ht_halted3", {31'h0, halted}, 32'h1);
`else
        chk("ht_halted", {31'h0, halted}, 32'h0);
        step();
        chk("ht_valid3", {31'h0, out_valid}, 32'h1);
        chk("ht_pc3",    out_pc,    32'hC);
        chk("ht_addr3",  imem_addr, 32'h4);
`endif
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk("ht_clear", {31'h0, halted}, 32'h0);
        step();
        chk("ht_rpc",  out_pc,    32'h0);
        chk("ht_rins", out_instr, 32'hA000_00AA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
